// File: rtl/mcm_driver.sv
// ============================================================================
// Module   : mcm_driver
// Brief    : Host-side initiator for the MCM core byte-serial interface.
//            Streams nine chain dimensions, awaits the cost strobe, compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcm_driver #(
  parameter int NDIM    = 9,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               START,
  input  logic [8*NDIM-1:0]  DIMS,
  input  logic [26:0]        EXP,
  output logic               MCM_IN_VALID,
  output logic [7:0]         MCM_IN,
  input  logic               MCM_OUT_VALID,
  input  logic [26:0]        MCM_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic [26:0]        RESULT,
  output logic               PASS,
  output logic               TIMEOUT_ERR
);

  localparam int IW = $clog2(NDIM + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_SEND = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;

  localparam logic [IW-1:0] c_LAST_IDX = IW'(NDIM - 1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]         state_q,    state_d;
  logic [8*NDIM-1:0]  shreg_q,    shreg_d;
  logic [26:0]        exp_q,      exp_d;
  logic [IW-1:0]      idx_q,      idx_d;
  logic [TW-1:0]      timer_q,    timer_d;
  logic               in_valid_q, in_valid_d;
  logic [7:0]         in_q,       in_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [26:0]        result_q,   result_d;
  logic               pass_q,     pass_d;
  logic               tmo_q,      tmo_d;

  logic w_last_byte;
  logic w_timer_expired;

  assign w_last_byte     = (idx_q == c_LAST_IDX);
  assign w_timer_expired = (timer_q == c_TMO_LAST);

  // State and all output registers; reset takes effect without a clock edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= c_IDLE;
      shreg_q    <= '0;
      exp_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
      in_valid_q <= 1'b0;
      in_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      exp_q      <= exp_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      in_valid_q <= in_valid_d;
      in_q       <= in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      pass_q     <= pass_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (START) state_d = c_SEND;
      c_SEND:  if (w_last_byte) state_d = c_WAIT;
      c_WAIT:  if (MCM_OUT_VALID || w_timer_expired) state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    shreg_d    = shreg_q;
    exp_d      = exp_q;
    idx_d      = idx_q;
    timer_d    = timer_q;
    in_valid_d = in_valid_q;
    in_d       = in_q;
    done_d     = 1'b0;
    result_d   = result_q;
    pass_d     = pass_q;
    tmo_d      = tmo_q;
    busy_d     = (state_d != c_IDLE);
    case (state_q)
      c_IDLE: begin
        if (START) begin
          // p0 goes out on the accepting edge; the rest wait in the shifter.
          shreg_d    = DIMS >> 8;
          exp_d      = EXP;
          idx_d      = '0;
          in_valid_d = 1'b1;
          in_d       = DIMS[7:0];
          tmo_d      = 1'b0;
          pass_d     = 1'b0;
        end
      end
      c_SEND: begin
        if (w_last_byte) begin
          in_valid_d = 1'b0;
          in_d       = '0;
          timer_d    = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          in_d    = shreg_q[7:0];
          shreg_d = shreg_q >> 8;
        end
      end
      c_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A strobe arriving on the final timer cycle still counts as a result.
        if (MCM_OUT_VALID) begin
          result_d = MCM_OUT;
          pass_d   = (MCM_OUT == exp_q);
          done_d   = 1'b1;
        end else if (w_timer_expired) begin
          tmo_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign MCM_IN_VALID = in_valid_q;
  assign MCM_IN       = in_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign RESULT       = result_q;
  assign PASS         = pass_q;
  assign TIMEOUT_ERR  = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_mcm_driver.sv
// ============================================================================
// Module   : tb_mcm_driver
// Brief    : Scoreboarded bench for mcm_driver with a behavioural MCM core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcm_driver;

  localparam int NDIM    = 9;
  localparam int TIMEOUT = 1023;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [71:0] DIMS;
  logic [26:0] EXP;
  logic        MCM_IN_VALID;
  logic [7:0]  MCM_IN;
  logic        MCM_OUT_VALID;
  logic [26:0] MCM_OUT;
  logic        BUSY;
  logic        DONE;
  logic [26:0] RESULT;
  logic        PASS;
  logic        TIMEOUT_ERR;

  mcm_driver #(.NDIM(NDIM), .TIMEOUT(TIMEOUT), .TW(10)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DIMS(DIMS), .EXP(EXP),
    .MCM_IN_VALID(MCM_IN_VALID), .MCM_IN(MCM_IN),
    .MCM_OUT_VALID(MCM_OUT_VALID), .MCM_OUT(MCM_OUT),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .PASS(PASS),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          to;
    logic [26:0] res;
    bit          pass;
  } out_t;

  logic [7:0] exp_bytes[$];
  out_t       exp_out[$];
  int n_chk = 0;
  int n_pass = 0;

  // Core behaviour controls (written by stimulus only).
  int core_mode = 0;      // 0 correct cost, 1 cost+1, 2 silent
  int core_mindly = 1;
  int core_maxdly = 6;
  bit core_spurious = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Minimum scalar multiplications for the chain p0..p8 (classic DP).
  function automatic longint mcm_cost(input logic [71:0] d);
    longint p[9];
    longint m[9][9];
    longint c;
    for (int k = 0; k < 9; k++) p[k] = longint'(d[8*k +: 8]);
    for (int i = 1; i <= 8; i++) m[i][i] = 0;
    for (int len = 2; len <= 8; len++) begin
      for (int i = 1; i <= 9 - len; i++) begin
        int j;
        j = i + len - 1;
        m[i][j] = 64'h7FFF_FFFF_FFFF_FFFF;
        for (int k = i; k < j; k++) begin
          c = m[i][k] + m[k+1][j] + p[i-1] * p[k] * p[j];
          if (c < m[i][j]) m[i][j] = c;
        end
      end
    end
    return m[1][8];
  endfunction

  // Behavioural MCM core: gathers nine bytes, replies after a random delay.
  initial begin
    logic [7:0]  got[$];
    logic [71:0] gd;
    logic [26:0] reply;
    int countdown;
    countdown = -1;
    reply = '0;
    MCM_OUT_VALID = 1'b0;
    MCM_OUT = '0;
    forever begin
      @(negedge CLK);
      MCM_OUT_VALID = 1'b0;
      if (!RESET) begin
        got.delete();
        countdown = -1;
        continue;
      end
      if (MCM_IN_VALID) begin
        got.push_back(MCM_IN);
        if (core_spurious && got.size() == 3) begin
          MCM_OUT_VALID = 1'b1;
          MCM_OUT = 27'h12345;
        end
        if (got.size() == NDIM) begin
          for (int k = 0; k < NDIM; k++) gd[8*k +: 8] = got[k];
          reply = 27'(mcm_cost(gd) + ((core_mode == 1) ? 1 : 0));
          if (core_mode != 2) countdown = core_mindly + $urandom_range(0, core_maxdly);
          got.delete();
        end
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          MCM_OUT_VALID = 1'b1;
          MCM_OUT = reply;
          countdown = -1;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a byte or an outcome.
  initial begin
    int cyc;
    int fall_cyc;
    bit prev_valid, prev_done, prev_to;
    out_t o;
    cyc = 0; fall_cyc = 0;
    prev_valid = 0; prev_done = 0; prev_to = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RESET) begin
        prev_valid = 0; prev_done = 0; prev_to = 0;
        continue;
      end
      if (MCM_IN_VALID) begin
        if (exp_bytes.size() == 0) fail_now("unexpected_byte");
        else chk("byte", 32'(MCM_IN), 32'(exp_bytes.pop_front()));
      end else if (prev_valid) begin
        chk("in_zero_after_send", 32'(MCM_IN), 0);
        fall_cyc = cyc;
      end
      if (DONE) begin
        chk("done_width", 32'(prev_done), 0);
        chk("busy_at_done", 32'(BUSY), 0);
        if (exp_out.size() == 0) fail_now("unexpected_done");
        else begin
          o = exp_out.pop_front();
          chk("outcome_is_result", 32'(o.to), 0);
          chk("result", 32'(RESULT), 32'(o.res));
          chk("pass", 32'(PASS), 32'(o.pass));
          chk("no_error_with_done", 32'(TIMEOUT_ERR), 0);
        end
      end
      if (TIMEOUT_ERR && !prev_to) begin
        if (exp_out.size() == 0) fail_now("unexpected_timeout");
        else begin
          o = exp_out.pop_front();
          chk("outcome_is_timeout", 32'(o.to), 1);
          chk("timeout_latency", 32'(cyc - fall_cyc), 32'(TIMEOUT));
          chk("busy_at_timeout", 32'(BUSY), 0);
          chk("no_done_at_timeout", 32'(DONE), 0);
        end
      end
      prev_valid = MCM_IN_VALID;
      prev_done  = DONE;
      prev_to    = TIMEOUT_ERR;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (BUSY && n < 3000) begin @(negedge CLK); n++; end
    if (BUSY) fail_now("wait_idle_bound");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_out.size() != 0 && n < 3000) begin @(negedge CLK); n++; end
    if (exp_out.size() != 0) fail_now("wait_outcome_bound");
  endtask

  task automatic push_txn(input logic [71:0] d, input logic [26:0] e,
                          input int mode, input logic [26:0] exp_res);
    out_t o;
    for (int k = 0; k < NDIM; k++) exp_bytes.push_back(d[8*k +: 8]);
    o.to   = (mode == 2);
    o.res  = exp_res;
    o.pass = (mode != 2) && (exp_res == e);
    exp_out.push_back(o);
  endtask

  // Issues one START at a negedge while idle and checks the accepting edge.
  task automatic issue(input logic [71:0] d, input logic [26:0] e,
                       input int mode, input logic [26:0] exp_res);
    wait_idle();
    core_mode = mode;
    DIMS = d; EXP = e; START = 1'b1;
    push_txn(d, e, mode, exp_res);
    @(negedge CLK);
    START = 1'b0;
    chk("start_busy", 32'(BUSY), 1);
    chk("start_valid", 32'(MCM_IN_VALID), 1);
    chk("start_clears_error", 32'(TIMEOUT_ERR), 0);
    chk("start_clears_pass", 32'(PASS), 0);
  endtask

  function automatic logic [71:0] seq_dims();
    logic [71:0] d;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'(k + 1);
    return d;
  endfunction

  initial begin
    logic [71:0] d;
    logic [26:0] e;
    int mode;
    longint cost;
    int n;

    RESET = 1'b0; START = 1'b0; DIMS = '0; EXP = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_valid", 32'(MCM_IN_VALID), 0);
    chk("rst_in", 32'(MCM_IN), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_result", 32'(RESULT), 0);
    chk("rst_pass", 32'(PASS), 0);
    chk("rst_error", 32'(TIMEOUT_ERR), 0);
    RESET = 1'b1;

    // Dims 1..9, correct reply 238.
    issue(seq_dims(), 27'd238, 0, 27'd238);
    wait_drain();

    // All ones, EXP=7, core answers 8.
    d = {9{8'd1}};
    issue(d, 27'd7, 1, 27'd8);
    wait_drain();

    // Silent core: timeout, sticky until the next START.
    d = 72'h0807_0605_0403_0201_09;
    issue(d, 27'd5, 2, 27'd0);
    wait_drain();
    repeat (3) @(negedge CLK);
    chk("error_sticky", 32'(TIMEOUT_ERR), 1);
    chk("result_kept_on_timeout", 32'(RESULT), 32'd8);

    // START during SEND and WAIT, stray strobe during SEND.
    for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'($urandom_range(1, 255));
    core_spurious = 1; core_mindly = 10;
    issue(d, 27'(mcm_cost(d)), 0, 27'(mcm_cost(d)));
    repeat (2) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_drain();
    repeat (2) @(negedge CLK);
    chk("no_queued_start", 32'(BUSY), 0);
    core_spurious = 0; core_mindly = 1;

    // Asynchronous reset on the 5th SEND cycle.
    issue(seq_dims(), 27'd238, 0, 27'd238);
    repeat (4) @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    chk("arst_valid", 32'(MCM_IN_VALID), 0);
    chk("arst_busy", 32'(BUSY), 0);
    chk("arst_result", 32'(RESULT), 0);
    chk("arst_pass", 32'(PASS), 0);
    exp_bytes.delete();
    exp_out.delete();
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    issue(seq_dims(), 27'd238, 0, 27'd238);
    wait_drain();

    // START held high across two transactions.
    wait_idle();
    core_mode = 0;
    DIMS = seq_dims(); EXP = 27'd238; START = 1'b1;
    push_txn(seq_dims(), 27'd238, 0, 27'd238);
    push_txn(seq_dims(), 27'd238, 0, 27'd238);
    n = 0;
    @(negedge CLK);
    while (!DONE && n < 3000) begin @(negedge CLK); n++; end
    if (!DONE) fail_now("held_done_bound");
    chk("held_gap_valid_low", 32'(MCM_IN_VALID), 0);
    @(negedge CLK);
    chk("held_retrigger", 32'(MCM_IN_VALID), 1);
    START = 1'b0;
    wait_drain();

    // Randomized transactions against the DP reference.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'($urandom_range(1, 255));
      mode = $urandom_range(0, 1);
      cost = mcm_cost(d);
      e = ($urandom_range(0, 1) == 1) ? 27'(cost) : 27'($urandom);
      issue(d, e, mode, 27'(cost + mode));
      wait_drain();
    end

    repeat (5) @(negedge CLK);
    chk("bytes_drained", 32'(exp_bytes.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcm_driver.md
Name: mcm_driver

Overview:
- Host-side initiator for the matrix-chain-multiplication (MCM) core's byte-serial interface: the other end of its IN_VALID/IN input and OUT_VALID/OUT result handshake.
- On START, latches nine 8-bit chain dimensions from a parallel bus and streams them to the core on consecutive cycles.
- Waits for the core's single-cycle result strobe, captures the 27-bit minimum cost and compares it with an expected value.
- Flags a timeout if no result arrives in time.
- Sits between a test/host controller and the MCM core.

Parameters:
- NDIM, 9, number of dimension bytes per transaction (8 matrices).
- TIMEOUT, 1023, maximum WAIT cycles before the timeout error is raised.
- TW, 10, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- CLK  in  1  system clock, all flops rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- START  in  1  request a transaction; sampled only in IDLE.
- DIMS  in  72  dimensions; byte k = DIMS[8k+7:8k] = p_k, k=0..8.
- EXP  in  27  expected minimum cost, latched with DIMS.
- MCM_IN_VALID  out  1  to core IN_VALID.
- MCM_IN  out  8  to core IN.
- MCM_OUT_VALID  in  1  from core OUT_VALID.
- MCM_OUT  in  27  from core OUT.
- BUSY  out  1  high whenever state != IDLE.
- DONE  out  1  one-cycle pulse when a result is captured.
- RESULT  out  27  last captured cost.
- PASS  out  1  RESULT == latched EXP; valid from DONE until next START.
- TIMEOUT_ERR  out  1  sticky error; cleared on an accepted START.

Behaviour:
- Reset is asynchronous, active-low, effective immediately, including mid-transaction. While RESET is low: state=IDLE, all outputs 0, MCM_IN_VALID=0, counters 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states:
  - IDLE -> SEND on START=1. On that same edge: DIMS and EXP are latched into a shift register, idx=0, MCM_IN_VALID<=1, MCM_IN<=p0, TIMEOUT_ERR<=0, PASS<=0.
  - SEND: each edge advances one byte. MCM_IN_VALID stays high for exactly NDIM consecutive cycles carrying p0..p8 in order. On the edge after p8, MCM_IN_VALID<=0, MCM_IN<=0, timer<=0, state -> WAIT.
  - WAIT: timer increments each cycle.
    - If MCM_OUT_VALID=1: RESULT<=MCM_OUT, PASS<=(MCM_OUT==EXP), DONE<=1 for one cycle, state -> IDLE.
    - Else if timer==TIMEOUT-1: TIMEOUT_ERR<=1, RESULT unchanged, state -> IDLE. No DONE pulse.
    - If MCM_OUT_VALID and timeout occur in the same cycle, the result wins: capture, no error.
- START outside IDLE is ignored; there is no queueing. START held high re-triggers on the first IDLE cycle, which is the cycle after DONE.
- MCM_OUT_VALID outside WAIT is ignored; RESULT, DONE and PASS are unaffected.
- Latency:
  - START edge -> MCM_IN_VALID high on the same edge (visible the following cycle).
  - The core sees the falling edge of IN_VALID NDIM cycles later.
  - DONE asserts on the edge after the cycle in which MCM_OUT_VALID=1.
- Back-to-back: minimum gap from DONE to the next MCM_IN_VALID is one cycle. This guarantees the core has returned to IDLE.
- Values pass through unmodified; no width conversion. Compare is a 27-bit unsigned equality.

Test Plan:
- Dims 1,2,3,4,5,6,7,8,9, EXP=238; bench core replies 238 -> MCM_IN shows 1..9 on 9 consecutive valid cycles, then DONE pulse, RESULT=238, PASS=1, BUSY falls with DONE.
- All dims = 1, EXP=7; core replies 8 -> RESULT=8, PASS=0, DONE=1 for exactly one cycle.
- Core never asserts OUT_VALID -> TIMEOUT_ERR=1 exactly TIMEOUT cycles after MCM_IN_VALID falls, no DONE, BUSY=0. The next START clears TIMEOUT_ERR.
- START pulsed during SEND and WAIT, plus MCM_OUT_VALID pulsed during SEND -> byte stream unchanged, only one DONE, RESULT taken from the WAIT-phase strobe.
- RESET driven low on the 5th SEND cycle -> MCM_IN_VALID drops immediately (asynchronously), BUSY=0. After release, a full transaction with dims 1..9 completes with RESULT=238.
- START held high across two transactions -> second MCM_IN_VALID rises exactly one cycle after the first DONE. Both results are captured and PASS=1.
